// File: rtl/stim_gen2lane_pkg.sv
// Shared definitions for the stimulus blocks: FSM state encoding, COM symbol and
// the LFSR tap list with its single-step helper.
package stim_gen2lane_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } stim_state_e;

  localparam int unsigned LFSR_W = 8;

  localparam logic [LFSR_W-1:0] COM_SYM = 8'hBC;

  // Feedback taps l[7], l[5], l[4], l[3]; feedback shifts into bit 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 8-bit payload LFSR with load and advance enables; exposes current and next value.
module stim_lfsr
  import stim_gen2lane_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [LFSR_W-1:0] next_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Load wins over advance so a fresh run always starts from SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;
  assign next_o  = lfsr_step(lfsr_q);

endmodule

// File: rtl/stim_gen2lane.sv
// Two-lane stimulus driver: COM preamble then PRBS payload over a valid/ready handshake.
// Optional build macro STIM_ERR_INJECT_EN flips lane-1 bit 0 on payload beat ERR_IDX.
module stim_gen2lane
  import stim_gen2lane_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       PRE_BEATS = 2,
  parameter int unsigned       NUM_WORDS = 16,
  parameter int unsigned       CNT_W     = 8,
  parameter logic [LFSR_W-1:0] SEED      = 8'hA5,
  parameter int unsigned       ERR_IDX   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count
);

  if (PRE_BEATS < 1 || NUM_WORDS < 1 || NUM_WORDS >= 2 ** CNT_W || ERR_IDX >= NUM_WORDS ||
      DATA_W != LFSR_W) begin : g_bad_cfg
    $error("stim_gen2lane: unsupported parameter set");
  end

  stim_state_e       state_q;
  logic [CNT_W-1:0]  pre_cnt_q;
  logic [CNT_W-1:0]  word_count_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic              valid_q, busy_q, done_q;

  logic              xfer;
  logic              lfsr_load, lfsr_adv;
  logic [LFSR_W-1:0] lfsr_cur, lfsr_nxt;
  logic [DATA_W-1:0] pay_d, lane1_d;

  assign xfer      = valid_q & ready_in;
  assign lfsr_load = (state_q == StIdle) & start;
  assign lfsr_adv  = (state_q == StSend) & xfer;

  stim_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (lfsr_load),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_cur),
    .next_o  (lfsr_nxt)
  );

  // Word loaded into the output registers on the transfer that starts the next payload beat.
  always_comb begin
    pay_d = (state_q == StPre) ? DATA_W'(lfsr_cur) : DATA_W'(lfsr_nxt);
  end

`ifdef STIM_ERR_INJECT_EN
  logic [CNT_W-1:0] beat_idx;
  always_comb begin
    beat_idx = (state_q == StPre) ? '0 : word_count_q + 1'b1;
    lane1_d  = ~pay_d ^ {{(DATA_W-1){1'b0}}, (beat_idx == CNT_W'(ERR_IDX))};
  end
`else
  always_comb begin
    lane1_d = ~pay_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pre_cnt_q    <= '0;
      word_count_q <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StPre;
            pre_cnt_q    <= '0;
            word_count_q <= '0;
            data0_q      <= DATA_W'(COM_SYM);
            data1_q      <= DATA_W'(COM_SYM);
            valid_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StPre: begin
          if (xfer) begin
            if (pre_cnt_q == CNT_W'(PRE_BEATS - 1)) begin
              state_q <= StSend;
              data0_q <= pay_d;
              data1_q <= lane1_d;
            end else begin
              pre_cnt_q <= pre_cnt_q + 1'b1;
            end
          end
        end
        StSend: begin
          if (xfer) begin
            word_count_q <= word_count_q + 1'b1;
            if (word_count_q == CNT_W'(NUM_WORDS - 1)) begin
              state_q <= StDone;
              data0_q <= '0;
              data1_q <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data0_q <= pay_d;
              data1_q <= lane1_d;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_out0  = data0_q;
  assign data_out1  = data1_q;
  assign valid_out0 = valid_q;
  assign valid_out1 = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_stim_gen2lane.sv
// Self-checking bench for stim_gen2lane against a beat-list reference model.
// Build with STIM_ERR_INJECT_EN defined to check the injected lane-1 error as well.
module tb_stim_gen2lane;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PRE_BEATS = 2;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned CNT_W     = 8;
  localparam logic [7:0]  SEED      = 8'hA5;
  localparam int unsigned ERR_IDX   = 3;
  localparam int          TOTAL     = PRE_BEATS + NUM_WORDS;
`ifdef STIM_ERR_INJECT_EN
  localparam int          ERR_EXP   = 1;
`else
  localparam int          ERR_EXP   = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, ready_in;
  logic [DATA_W-1:0] data_out0, data_out1;
  logic              valid_out0, valid_out1, busy, done;
  logic [CNT_W-1:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] e0 [TOTAL];
  logic [7:0] e1 [TOTAL];

  always #5 clk = ~clk;

  stim_gen2lane #(
    .DATA_W    (DATA_W),
    .PRE_BEATS (PRE_BEATS),
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W),
    .SEED      (SEED),
    .ERR_IDX   (ERR_IDX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ready_in   (ready_in),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  function automatic logic [7:0] prbs_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Expected beat list of one run: COM preamble, then SEED and its successors.
  task automatic build_model();
    logic [7:0] l;
    l = SEED;
    for (int k = 0; k < PRE_BEATS; k++) begin
      e0[k] = 8'hBC;
      e1[k] = 8'hBC;
    end
    for (int j = 0; j < NUM_WORDS; j++) begin
      e0[PRE_BEATS+j] = l;
      e1[PRE_BEATS+j] = ~l;
`ifdef STIM_ERR_INJECT_EN
      if (j == ERR_IDX) e1[PRE_BEATS+j] = ~l ^ 8'h01;
`endif
      l = prbs_next(l);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom);
      ready_in = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({data_out0, data_out1, valid_out0, valid_out1, busy, done, word_count} !== '0) begin
        n_bad++;
        $display("FAIL reset[%0d]: d0=%h d1=%h v=%b%b busy=%b done=%b wc=%0d, required all 0",
                 i, data_out0, data_out1, valid_out0, valid_out1, busy, done, word_count);
      end
    end
    reset    = 1'b0;
    start    = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int nflag;
    nflag    = 0;
    ready_in = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= TOTAL; k++) begin
      n_cmp++;
      if (valid_out0 !== 1'b1 || valid_out1 !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          data_out0 !== e0[k-1] || data_out1 !== e1[k-1] ||
          word_count !== CNT_W'((k <= PRE_BEATS) ? 0 : k - 1 - PRE_BEATS)) begin
        n_bad++;
        $display("FAIL nominal_t%0d: d=%h/%h v=%b busy=%b done=%b wc=%0d, required %h/%h v=1 busy=1 done=0",
                 k, data_out0, data_out1, valid_out0, busy, done, word_count, e0[k-1], e1[k-1]);
      end
      if (k > PRE_BEATS && data_out1 !== ~data_out0) nflag++;
      if (k == 3 || k == 4) begin
        n_cmp++;
        if ({data_out0, data_out1} !== ((k == 3) ? 16'hA55A : 16'h4AB5)) begin
          n_bad++;
          $display("FAIL nominal_lit_t%0d: got %h/%h, required %s", k, data_out0, data_out1,
                   (k == 3) ? "A5/5A" : "4A/B5");
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done !== 1'b1 || valid_out0 !== 1'b0 || busy !== 1'b0 || data_out0 !== '0 ||
        word_count !== CNT_W'(NUM_WORDS)) begin
      n_bad++;
      $display("FAIL nominal_done_t%0d: done=%b v=%b busy=%b d0=%h wc=%0d, required done=1 v=0 busy=0 d0=0 wc=%0d",
               TOTAL + 1, done, valid_out0, busy, data_out0, word_count, NUM_WORDS);
    end
    n_cmp++;
    if (nflag !== ERR_EXP) begin
      n_bad++;
      $display("FAIL nominal_errflag: lane mismatches=%0d, required %0d", nflag, ERR_EXP);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || word_count !== CNT_W'(NUM_WORDS)) begin
      n_bad++;
      $display("FAIL nominal_after: done=%b busy=%b wc=%0d, required done=0 busy=0 wc=%0d",
               done, busy, word_count, NUM_WORDS);
    end
  endtask

  // rnd=0: five-cycle stall on payload beat 1; rnd=1: random ready throughout.
  task automatic test_backpressure(input bit rnd);
    int ptr, stall, ndone, wexp;
    bit rdy;
    ptr      = 0;
    stall    = 0;
    ndone    = 0;
    ready_in = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && ndone == 0; cyc++) begin
      wexp = (ptr > PRE_BEATS) ? ptr - PRE_BEATS : 0;
      if (done === 1'b1) begin
        ndone++;
        n_cmp++;
        if (ptr != TOTAL || valid_out0 !== 1'b0 || word_count !== CNT_W'(NUM_WORDS)) begin
          n_bad++;
          $display("FAIL bp_done(rnd=%0d): beats=%0d v=%b wc=%0d, required beats=%0d v=0 wc=%0d",
                   rnd, ptr, valid_out0, word_count, TOTAL, NUM_WORDS);
        end
      end else begin
        n_cmp++;
        if (ptr >= TOTAL || valid_out0 !== 1'b1 || valid_out1 !== 1'b1 || busy !== 1'b1 ||
            data_out0 !== e0[ptr] || data_out1 !== e1[ptr] || word_count !== CNT_W'(wexp)) begin
          n_bad++;
          $display("FAIL bp_beat%0d(rnd=%0d): d=%h/%h v=%b%b busy=%b wc=%0d, required %h/%h v=11 busy=1 wc=%0d",
                   ptr, rnd, data_out0, data_out1, valid_out0, valid_out1, busy, word_count,
                   (ptr < TOTAL) ? e0[ptr] : 8'h00, (ptr < TOTAL) ? e1[ptr] : 8'h00, wexp);
        end
      end
      if (rnd) rdy = ($urandom_range(3) != 0);
      else     rdy = !(ptr == PRE_BEATS + 1 && stall < 5);
      if (!rdy && ptr == PRE_BEATS + 1) stall++;
      ready_in = rdy;
      if (rdy && valid_out0 === 1'b1) ptr++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone != 1 || (!rnd && stall != 5)) begin
      n_bad++;
      $display("FAIL bp_complete(rnd=%0d): done pulses=%0d stalls=%0d, required 1 done, 5 stalls",
               rnd, ndone, stall);
    end
    ready_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    ready_in = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (PRE_BEATS + 5) @(negedge clk);
    n_cmp++;
    if (data_out0 !== e0[PRE_BEATS+5]) begin
      n_bad++;
      $display("FAIL midrst_beat5: d0=%h, required %h", data_out0, e0[PRE_BEATS+5]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({data_out0, data_out1, valid_out0, valid_out1, busy, done, word_count} !== '0) begin
      n_bad++;
      $display("FAIL midrst_zero: d=%h/%h v=%b busy=%b done=%b wc=%0d, required all 0",
               data_out0, data_out1, valid_out0, busy, done, word_count);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || valid_out0 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_nodone: done=%b v=%b, required done=0 v=0", done, valid_out0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= PRE_BEATS; k++) begin
      n_cmp++;
      if (valid_out0 !== 1'b1 || data_out0 !== e0[k] || data_out1 !== e1[k]) begin
        n_bad++;
        $display("FAIL midrst_replay%0d: d=%h/%h v=%b, required %h/%h v=1",
                 k, data_out0, data_out1, valid_out0, e0[k], e1[k]);
      end
      @(negedge clk);
    end
    repeat (NUM_WORDS + 2) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int ndone;
    ndone    = 0;
    ready_in = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= TOTAL; k++) begin
      n_cmp++;
      if (valid_out0 !== 1'b1 || done !== 1'b0 || data_out0 !== e0[k-1] ||
          data_out1 !== e1[k-1]) begin
        n_bad++;
        $display("FAIL ign_t%0d: d=%h/%h v=%b done=%b, required %h/%h v=1 done=0",
                 k, data_out0, data_out1, valid_out0, done, e0[k-1], e1[k-1]);
      end
      start = (k == 5 || k == TOTAL);
      @(negedge clk);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (valid_out0 !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_idle: v=%b busy=%b done=%b, required 0/0/0", valid_out0, busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (valid_out0 !== 1'b1 || busy !== 1'b1 || data_out0 !== 8'hBC || word_count !== '0) begin
      n_bad++;
      $display("FAIL ign_relaunch: v=%b busy=%b d0=%h wc=%0d, required v=1 busy=1 d0=bc wc=0",
               valid_out0, busy, data_out0, word_count);
    end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_single_run: done pulses=%0d busy=%b, required 1 pulse busy=0", ndone, busy);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    ready_in = 1'b0;
    build_model();
    test_reset();
    test_nominal();
    test_backpressure(1'b0);
    for (int r = 0; r < 4; r++) test_backpressure(1'b1);
    test_reset_mid_run();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
